hf_mode_ctrl: RTL and testbench
===============================

// Module: hf_mode_ctrl
// PURPOSE
//  Next-generation HF front-end controller: receives SPI command frames from the ARM, keeps
//  N_REGS configuration registers and routes one of N_MODES mode-module output bundles to pins.
//  Mode changes are glitch-free break-before-make: all outputs are idled for GUARD cycles.
//  Sits at top level between the SPI pins, the hi_* mode modules and the coil/ADC/SSP pins.
// PARAMETERS
//  N_MODES   5   number of mode modules on mode_bus_i; mode index >= N_MODES = off
//  OUT_W     11  bits per mode bundle (ssp_clk/din/frame, pwr_oe1..4, pwr_lo/hi, adc_clk, dbg)
//  N_REGS    4   config registers; SPI command c in 1..N_REGS writes reg c-1
//  DATA_W    12  data field width of a frame; FRAME_W = 4 + DATA_W
//  MODE_LSB  5   position of the 3-bit major_mode field in reg 0
//  GUARD     4   idle cycles between modes (1..255)
// PORTS
//  ck_1356meg  in   1               system clock; all logic on rising edge
//  rst         in   1               synchronous, active-high reset
//  spck        in   1               SPI clock (async to ck_1356meg)
//  mosi        in   1               SPI data, MSB first
//  ncs         in   1               SPI select, active low
//  mode_bus_i  in   N_MODES*OUT_W   bundle k at [k*OUT_W +: OUT_W]
//  bus_o       out  OUT_W           registered selected bundle, 0 when idle/off
//  conf_o      out  N_REGS*DATA_W   config registers, reg k at [k*DATA_W +: DATA_W]
//  active_mode out  3               mode currently driving bus_o
//  switching   out  1               high during guard interval
//  frame_err   out  1               1-cycle pulse: frame with bit count != FRAME_W
//  cmd_ign     out  1               1-cycle pulse: valid-length frame, cmd 0 or > N_REGS
// BEHAVIOUR
//  Reset: conf_o=0, bus_o=0, active_mode=3'b111, switching=0, pulses=0, bitcnt=0, FSM=RUN.
//  Input sync: spck/ncs/mosi each through 2 flops; edges are detected on the synced copies.
//  SPI constraint: each spck phase and ncs high time >= 2 clk cycles; faster is unsupported.
//  Shift: on synced spck rise with ncs_s low: shift <= {shift, mosi_s}; bitcnt saturates at FRAME_W+1.
//  bitcnt clears on the ncs_s fall. ncs_s rise ends the frame:
//   bitcnt==FRAME_W: cmd = shift[FRAME_W-1 -: 4]; cmd 1..N_REGS -> reg[cmd-1] <= shift[DATA_W-1:0];
//     otherwise cmd_ign pulses.
//   bitcnt!=FRAME_W: frame_err pulses; no register write.
//  Latency: conf_o updates on the 3rd clk edge after raw ncs rises.
//  req_mode = reg0[MODE_LSB+2:MODE_LSB].
//  FSM RUN: bus_o <= (active_mode<N_MODES) ? bundle[active_mode] : 0; 1 cycle registered.
//   RUN -> BREAK when req_mode != active_mode: bus_o <= 0, switching=1, gcnt <= GUARD-1.
//   BREAK: bus_o held 0; gcnt decrements. At gcnt==0: active_mode <= req_mode sampled that cycle.
//     switching=0 and the FSM returns to RUN.
//   A req_mode change during BREAK does not restart gcnt; the latest value wins.
//     If the result equals the old mode, the guard still completes.
//  Off mode (req_mode >= N_MODES): the same guard applies; bus_o stays 0 in RUN.
//  rst mid-frame: shift/bitcnt cleared. The partial frame is dropped and raises no frame_err.
//    ncs may still be low after rst; the next frame then counts as short and raises frame_err.
//  rst mid-BREAK: returns to the reset state.
//  After reset, req_mode=0 != 111: one guard interval, then mode 0 is active.
// STRUCTURE
//  Include file hf_mode_pkg.vh holds:
//    FPGA_CMD_SET_CONFREG=4'd1, command codes 2..N_REGS, FRAME_W, and MODE_OFF=3'b111.
//  Sub-module hf_spi_frame_rx: sync, shifter, bitcnt, frame_done/frame_err strobes.
//  The top holds the register file, the RUN/BREAK FSM and the bundle mux.
// TESTING
//  1 rst 3 cycles, hold -> bus_o=0, active_mode=111; GUARD+2 cycles later active_mode=0.
//  2 frame 16'h1_0A5 then 16'h2_123 -> reg0=12'h0A5, reg1=12'h123.
//    reg0 mode field=5 -> off: guard, then bus_o=0.
//  3 frame 16'h1_020 (mode 1) while mode 0 runs, bundle0=11'h7FF, bundle1=11'h155.
//    -> bus_o 7FF, then exactly GUARD zero cycles, then 155.
//  4 15-bit frame, then 17-bit frame -> frame_err pulses twice; conf_o unchanged.
//  5 frame 16'h0_FFF and 16'hF_FFF -> cmd_ign pulses twice; conf_o unchanged.
//  6 mode 0->1, then 1->2 mid-guard; separately rst after 8 bits.
//    -> single guard, then mode 2; next full frame decodes correctly.

Source files
------------

// File: rtl/hf_mode_ctrl_pkg.sv
// Shared constants and types for the HF front-end mode controller.
// Holds the SPI command codes, frame geometry defaults, the off-mode code and FSM state type.
// Imported by hf_spi_frame_rx and hf_mode_ctrl; contains no logic of its own.
package hf_mode_ctrl_pkg;

    // Default geometry; the modules expose these as overridable parameters.
    localparam int N_MODES_DEF  = 5;
    localparam int OUT_W_DEF    = 11;
    localparam int N_REGS_DEF   = 4;
    localparam int DATA_W_DEF   = 12;
    localparam int MODE_LSB_DEF = 5;
    localparam int GUARD_DEF    = 4;

    // A frame is a 4-bit command followed by the data field, MSB first.
    localparam int CMD_W   = 4;
    localparam int FRAME_W = CMD_W + DATA_W_DEF;

    // Command c writes config register c-1. Codes outside 1..N_REGS are ignored.
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG  = 4'd1;
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG1 = 4'd2;
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG2 = 4'd3;
    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG3 = 4'd4;

    // Active-mode code meaning "no mode module drives the pins".
    localparam logic [2:0] MODE_OFF = 3'b111;

    // Output-routing FSM: RUN forwards a bundle, BREAK idles the pins.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BREAK = 1'b1
    } mode_state_e;

endpackage

// File: rtl/hf_spi_frame_rx.sv
// SPI frame receiver: synchronises spck/ncs/mosi, shifts bits MSB first, counts frame length.
// Latency: frame_vld/frame_err strobe in the cycle the synchronised ncs is seen rising (2 clk after raw ncs).
// No backpressure: one strobe per frame, the consumer must take it in that cycle.
module hf_spi_frame_rx
    import hf_mode_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAME_W = CMD_W + DATA_W
) (
    input  logic               ck_1356meg,  // system clock
    input  logic               rst,         // synchronous, active-high
    input  logic               spck,        // raw SPI clock
    input  logic               mosi,        // raw SPI data
    input  logic               ncs,         // raw SPI select, active low
    output logic               frame_vld,   // frame of exactly FRAME_W bits ended
    output logic               frame_err,   // frame of any other length ended
    output logic [FRAME_W-1:0] frame_dat    // last FRAME_W bits shifted in
);

    // Counter saturates at FRAME_W+1 so over-long frames stay distinguishable.
    localparam int                CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [1:0]         spck_sync_q, spck_sync_d;
    logic [1:0]         mosi_sync_q, mosi_sync_d;
    logic [1:0]         ncs_sync_q,  ncs_sync_d;
    logic               spck_prev_q, spck_prev_d;
    logic               ncs_prev_q,  ncs_prev_d;
    logic [FRAME_W-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]   bitcnt_q,    bitcnt_d;

    logic spck_s, mosi_s, ncs_s;
    logic spck_rise, ncs_fall, ncs_rise;

    assign spck_s = spck_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
    assign ncs_s  = ncs_sync_q[1];

    assign spck_rise = spck_s & ~spck_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    always_comb begin
        spck_sync_d = {spck_sync_q[0], spck};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        ncs_sync_d  = {ncs_sync_q[0], ncs};
        spck_prev_d = spck_s;
        ncs_prev_d  = ncs_s;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;

        if (spck_rise && !ncs_s) begin
            shift_d = {shift_q[FRAME_W-2:0], mosi_s};
        end

        // A new select clears the count; counting only while selected.
        if (ncs_fall) begin
            bitcnt_d = '0;
        end else if (spck_rise && !ncs_s && (bitcnt_q != CNT_SAT)) begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            // Select resets to its idle (high) level so a still-low ncs after
            // reset shows up as a fresh falling edge and restarts the count.
            spck_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b11;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            shift_q     <= '0;
            bitcnt_q    <= '0;
        end else begin
            spck_sync_q <= spck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            spck_prev_q <= spck_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
        end
    end

    assign frame_vld = ncs_rise & (bitcnt_q == CNT_FULL);
    assign frame_err = ncs_rise & (bitcnt_q != CNT_FULL);
    assign frame_dat = shift_q;

endmodule

// File: rtl/hf_mode_ctrl.sv
// HF front-end controller: SPI-written config registers and break-before-make mode output mux.
// Latency: conf_o on 3rd clk edge after raw ncs rise; bus_o 1 cycle registered; GUARD idle cycles per mode change.
// No backpressure: SPI frames are consumed as they end; mode changes during a guard merge into it.
//
// Ports: ck_1356meg/rst clock and sync reset; spck/mosi/ncs raw SPI; mode_bus_i N_MODES bundles;
//        bus_o selected bundle; conf_o packed config regs; active_mode/switching routing status;
//        frame_err/cmd_ign one-cycle event pulses.
module hf_mode_ctrl
    import hf_mode_ctrl_pkg::*;
#(
    parameter int N_MODES  = N_MODES_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int N_REGS   = N_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MODE_LSB = MODE_LSB_DEF,
    parameter int GUARD    = GUARD_DEF
) (
    input  logic                      ck_1356meg,
    input  logic                      rst,
    input  logic                      spck,
    input  logic                      mosi,
    input  logic                      ncs,
    input  logic [N_MODES*OUT_W-1:0]  mode_bus_i,
    output logic [OUT_W-1:0]          bus_o,
    output logic [N_REGS*DATA_W-1:0]  conf_o,
    output logic [2:0]                active_mode,
    output logic                      switching,
    output logic                      frame_err,
    output logic                      cmd_ign
);

    localparam int         FW        = CMD_W + DATA_W;
    localparam logic [7:0] GCNT_INIT = 8'(GUARD - 1);

    // ------------------------------------------------------------------
    // SPI frame reception
    // ------------------------------------------------------------------
    logic          rx_frame_vld;
    logic          rx_frame_err;
    logic [FW-1:0] rx_frame_dat;

    hf_spi_frame_rx #(
        .DATA_W  (DATA_W),
        .FRAME_W (FW)
    ) u_spi_rx (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .spck       (spck),
        .mosi       (mosi),
        .ncs        (ncs),
        .frame_vld  (rx_frame_vld),
        .frame_err  (rx_frame_err),
        .frame_dat  (rx_frame_dat)
    );

    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] cmd_data;

    assign cmd      = rx_frame_dat[FW-1 -: CMD_W];
    assign cmd_data = rx_frame_dat[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Config register file and event pulses
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] conf_q [N_REGS];
    logic [DATA_W-1:0] conf_d [N_REGS];
    logic              frame_err_q, frame_err_d;
    logic              cmd_ign_q,   cmd_ign_d;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            conf_d[k] = conf_q[k];
        end
        frame_err_d = rx_frame_err;
        cmd_ign_d   = 1'b0;

        if (rx_frame_vld) begin
            // Command codes are contiguous from FPGA_CMD_SET_CONFREG upward.
            for (int k = 0; k < N_REGS; k++) begin
                if (cmd == FPGA_CMD_SET_CONFREG + CMD_W'(k)) begin
                    conf_d[k] = cmd_data;
                end
            end
            if ((cmd < FPGA_CMD_SET_CONFREG) || (cmd > CMD_W'(N_REGS))) begin
                cmd_ign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            for (int k = 0; k < N_REGS; k++) begin
                conf_q[k] <= '0;
            end
            frame_err_q <= 1'b0;
            cmd_ign_q   <= 1'b0;
        end else begin
            for (int k = 0; k < N_REGS; k++) begin
                conf_q[k] <= conf_d[k];
            end
            frame_err_q <= frame_err_d;
            cmd_ign_q   <= cmd_ign_d;
        end
    end

    always_comb begin
        conf_o = '0;
        for (int k = 0; k < N_REGS; k++) begin
            conf_o[k*DATA_W +: DATA_W] = conf_q[k];
        end
    end

    assign frame_err = frame_err_q;
    assign cmd_ign   = cmd_ign_q;

    // ------------------------------------------------------------------
    // Mode routing FSM with guard interval
    // ------------------------------------------------------------------
    logic [2:0] req_mode;
    assign req_mode = conf_q[0][MODE_LSB+2:MODE_LSB];

    // Bundle for a mode index; indices at or above N_MODES select all-zero.
    function automatic logic [OUT_W-1:0] pick_bundle(
        input logic [N_MODES*OUT_W-1:0] bus,
        input logic [2:0]               mode
    );
        logic [OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_MODES; k++) begin
            if (mode == 3'(k)) begin
                r = bus[k*OUT_W +: OUT_W];
            end
        end
        return r;
    endfunction

    mode_state_e      state_q,  state_d;
    logic [7:0]       gcnt_q,   gcnt_d;
    logic [2:0]       active_q, active_d;
    logic [OUT_W-1:0] bus_q,    bus_d;

    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        active_d = active_q;
        bus_d    = bus_q;

        case (state_q)
            ST_RUN: begin
                if (req_mode != active_q) begin
                    state_d = ST_BREAK;
                    gcnt_d  = GCNT_INIT;
                    bus_d   = '0;
                end else begin
                    bus_d = pick_bundle(mode_bus_i, active_q);
                end
            end
            ST_BREAK: begin
                bus_d = '0;
                if (gcnt_q == 8'd0) begin
                    // req_mode is sampled only here, so changes during the
                    // guard collapse into one switch to the latest request.
                    // Loading the new bundle on this last guard cycle makes
                    // the pins idle for exactly GUARD cycles.
                    state_d  = ST_RUN;
                    active_d = req_mode;
                    bus_d    = pick_bundle(mode_bus_i, req_mode);
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state_q  <= ST_RUN;
            gcnt_q   <= 8'd0;
            active_q <= MODE_OFF;
            bus_q    <= '0;
        end else begin
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            active_q <= active_d;
            bus_q    <= bus_d;
        end
    end

    assign bus_o       = bus_q;
    assign active_mode = active_q;
    assign switching   = (state_q == ST_BREAK);

endmodule

// File: tb/tb_hf_mode_ctrl.sv
// Directed plus randomized checks of hf_mode_ctrl against a register/mode reference model.
module tb_hf_mode_ctrl;

    localparam int NM = 5;
    localparam int OW = 11;
    localparam int NR = 4;
    localparam int DW = 12;
    localparam int ML = 5;
    localparam int G  = 100;  // long guard so a second frame can land inside it
    localparam int PH = 2;    // SPI phase length in clk cycles

    logic                clk = 1'b0;
    logic                rst;
    logic                spck;
    logic                mosi;
    logic                ncs;
    logic [NM*OW-1:0]    mode_bus;
    logic [OW-1:0]       bus_o;
    logic [NR*DW-1:0]    conf_o;
    logic [2:0]          active_mode;
    logic                switching;
    logic                frame_err;
    logic                cmd_ign;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] exp_reg [NR];
    int            exp_ferr = 0;
    int            exp_cign = 0;

    // Event counters written only by the monitor
    int   n_ferr = 0;
    int   n_cign = 0;
    int   n_sw   = 0;
    int   n_m1   = 0;
    logic sw_prev = 1'b0;

    always #5 clk = ~clk;

    hf_mode_ctrl #(
        .N_MODES (NM), .OUT_W (OW), .N_REGS (NR), .DATA_W (DW),
        .MODE_LSB (ML), .GUARD (G)
    ) dut (
        .ck_1356meg  (clk),
        .rst         (rst),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs),
        .mode_bus_i  (mode_bus),
        .bus_o       (bus_o),
        .conf_o      (conf_o),
        .active_mode (active_mode),
        .switching   (switching),
        .frame_err   (frame_err),
        .cmd_ign     (cmd_ign)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (cmd_ign === 1'b1) n_cign++;
        if (switching === 1'b1 && sw_prev === 1'b0) n_sw++;
        sw_prev = switching;
        if (active_mode === 3'd1) n_m1++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_conf();
        logic [NR*DW-1:0] r;
        for (int k = 0; k < NR; k++) r[k*DW +: DW] = exp_reg[k];
        return r;
    endfunction

    function automatic logic [2:0] exp_mode();
        logic [DW-1:0] r0;
        r0 = exp_reg[0];
        return r0[ML+2:ML];
    endfunction

    function automatic logic [OW-1:0] exp_bus(input logic [2:0] m);
        if (int'(m) < NM) return mode_bus[int'(m)*OW +: OW];
        return '0;
    endfunction

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            spck = 1'b0;
            cyc(PH);
            spck = 1'b1;
            cyc(PH);
        end
        spck = 1'b0;
        cyc(PH);
    endtask

    // Send a complete frame and update the model from the frame rules.
    task automatic frame(input logic [31:0] bits, input int n);
        int c;
        ncs = 1'b0;
        cyc(PH);
        send_bits(bits, n);
        ncs = 1'b1;
        cyc(PH);
        if (n == DW + 4) begin
            c = int'(bits[DW+3:DW]);
            if (c >= 1 && c <= NR) exp_reg[c-1] = bits[DW-1:0];
            else exp_cign++;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_steady(input string tag);
        chk({tag, "_conf"}, 64'(conf_o), 64'(exp_conf()));
        chk({tag, "_mode"}, 64'(active_mode), 64'(exp_mode()));
        chk({tag, "_bus"}, 64'(bus_o), 64'(exp_bus(exp_mode())));
    endtask

    initial begin
        int w, z, sw0, m10;
        logic [31:0] b;
        rst = 1'b1; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
        mode_bus = '0;
        mode_bus[0*OW +: OW] = 11'h7FF;
        mode_bus[1*OW +: OW] = 11'h155;
        mode_bus[2*OW +: OW] = 11'h2AA;
        mode_bus[3*OW +: OW] = 11'h0F0;
        mode_bus[4*OW +: OW] = 11'h30C;
        for (int k = 0; k < NR; k++) exp_reg[k] = '0;

        // 1: reset state, then guard into mode 0
        cyc(3);
        chk("rst_bus", 64'(bus_o), 64'(0));
        chk("rst_mode", 64'(active_mode), 64'(3'b111));
        chk("rst_sw", 64'(switching), 64'(0));
        chk("rst_conf", 64'(conf_o), 64'(0));
        chk("rst_pulses", 64'({frame_err, cmd_ign}), 64'(0));
        rst = 1'b0;
        cyc(G / 2);
        chk("guard0_sw", 64'(switching), 64'(1));
        chk("guard0_bus", 64'(bus_o), 64'(0));
        cyc(G + 2 - G / 2);
        chk("guard0_mode", 64'(active_mode), 64'(0));
        chk("guard0_busrun", 64'(bus_o), 64'(11'h7FF));

        // 3: mode 0 -> 1 gives exactly G idle cycles
        frame(32'h1020, 16);
        chk("t3_pre", 64'(bus_o), 64'(11'h7FF));
        w = 0;
        while (bus_o == 11'h7FF && w < 20) begin cyc(1); w++; end
        z = 0;
        while (bus_o == '0 && z < G + 20) begin cyc(1); z++; end
        chk("t3_zero_cycles", 64'(z), 64'(G));
        chk("t3_new_bus", 64'(bus_o), 64'(11'h155));
        cyc(5);
        check_steady("t3");

        // 2: two register writes; reg0 mode field 5 means off
        frame(32'h10A5, 16);
        frame(32'h2123, 16);
        cyc(G + 20);
        chk("t2_reg0", 64'(conf_o[DW-1:0]), 64'(12'h0A5));
        chk("t2_reg1", 64'(conf_o[2*DW-1:DW]), 64'(12'h123));
        chk("t2_mode", 64'(active_mode), 64'(5));
        chk("t2_bus", 64'(bus_o), 64'(0));

        // 4: short and long frames
        frame(32'h00001A5A, 15);
        frame(32'h0001A5A5, 17);
        cyc(10);
        chk("t4_ferr", 64'(n_ferr), 64'(exp_ferr));
        chk("t4_conf", 64'(conf_o), 64'(exp_conf()));

        // 5: ignored commands
        frame(32'h0FFF, 16);
        frame(32'hFFFF, 16);
        cyc(10);
        chk("t5_cign", 64'(n_cign), 64'(exp_cign));
        chk("t5_conf", 64'(conf_o), 64'(exp_conf()));

        // 6a: 0 -> 1 then 1 -> 2 inside the guard collapses to one switch
        frame(32'h1000, 16);
        cyc(G + 20);
        check_steady("t6_start");
        sw0 = n_sw;
        m10 = n_m1;
        frame(32'h1020, 16);
        frame(32'h1040, 16);
        cyc(G + 20);
        chk("t6_one_guard", 64'(n_sw - sw0), 64'(1));
        chk("t6_no_mode1", 64'(n_m1 - m10), 64'(0));
        check_steady("t6_end");

        // 6b: reset after 8 bits, ncs still low afterwards
        ncs = 1'b0;
        cyc(PH);
        send_bits(32'hA5, 8);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) exp_reg[k] = '0;
        chk("t6_rst_conf", 64'(conf_o), 64'(0));
        chk("t6_rst_noferr", 64'(n_ferr), 64'(exp_ferr));
        send_bits(32'h3C, 8);
        ncs = 1'b1;
        cyc(PH);
        exp_ferr++;
        cyc(G + 20);
        chk("t6_short_ferr", 64'(n_ferr), 64'(exp_ferr));
        check_steady("t6_after_rst");
        frame(32'h2ABC, 16);
        cyc(10);
        chk("t6_decode", 64'(conf_o), 64'(exp_conf()));

        // Randomized frames and bundles against the model
        for (int it = 0; it < 12; it++) begin
            int n;
            mode_bus = {$urandom, $urandom};
            b = $urandom;
            b[15:12] = 4'($urandom_range(0, 5));
            n = ($urandom_range(0, 4) == 0) ? (15 + 2 * int'($urandom_range(0, 1))) : 16;
            frame(b, n);
            cyc(G + 20);
            check_steady("rand");
            chk("rand_ferr", 64'(n_ferr), 64'(exp_ferr));
            chk("rand_cign", 64'(n_cign), 64'(exp_cign));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
